// File: rtl/axi_lite_regfile_slave_pkg.sv
// Shared AXI-Lite definitions: response codes and the write/read FSM state
// encodings used by the register-file slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_lite_regfile_slave_if.sv
// AXI-Lite bus bundle between a master and the register-file slave.
interface axi_lite_regfile_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axi_lite_regfile_slave_strb_merge.sv
// Byte-lane merge: each lane takes the new byte when its strobe is set,
// otherwise keeps the old byte.
module axi_strb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   i_old,
    input  logic [DATA_W-1:0]   i_new,
    input  logic [DATA_W/8-1:0] i_strb,
    output logic [DATA_W-1:0]   o_data
);

    for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
        assign o_data[b*8 +: 8] = i_strb[b] ? i_new[b*8 +: 8] : i_old[b*8 +: 8];
    end

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite register file: independent write (AW/W/B) and read (AR/R) FSMs
// over NUM_REGS word-indexed registers with per-register read-only masking.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int                   DATA_W    = 32,
    parameter int                   ADDR_W    = 32,
    parameter int                   NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    axi_lite_regfile_slave_if.slave      s_axi,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int STRB_W = DATA_W / 8;

    // r_live keeps every READY low while in reset and until the first edge after release
    logic                   r_live;
    w_state_e               r_wst, w_wst_nxt;
    r_state_e               r_rst, w_rst_nxt;

    logic [ADDR_W-1:0]      r_awaddr;
    logic [DATA_W-1:0]      r_wdata;
    logic [STRB_W-1:0]      r_wstrb;
    logic [1:0]             r_bresp;

    logic [DATA_W-1:0]      r_rdata;
    logic [1:0]             r_rresp;

    logic [DATA_W-1:0]      r_regs   [NUM_REGS];
    logic [DATA_W-1:0]      w_merged [NUM_REGS];
    logic [NUM_REGS-1:0]    r_wr_pulse;

    logic                   w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                   w_commit, w_wr_err, w_rd_err;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_data;
    logic [STRB_W-1:0]      w_strb;
    logic [NUM_REGS-1:0]    w_wr_hit, w_rd_hit, w_sel;
    logic [DATA_W-1:0]      w_rd_data;

    assign s_axi.AWREADY = r_live & ((r_wst == W_IDLE) | (r_wst == W_HAVE_W));
    assign s_axi.WREADY  = r_live & ((r_wst == W_IDLE) | (r_wst == W_HAVE_AW));
    assign s_axi.BVALID  = (r_wst == W_RESP);
    assign s_axi.BRESP   = r_bresp;
    assign s_axi.ARREADY = r_live & (r_rst == R_IDLE);
    assign s_axi.RVALID  = (r_rst == R_DATA);
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;

    assign w_aw_hs = s_axi.AWVALID & s_axi.AWREADY;
    assign w_w_hs  = s_axi.WVALID  & s_axi.WREADY;
    assign w_b_hs  = s_axi.BVALID  & s_axi.BREADY;
    assign w_ar_hs = s_axi.ARVALID & s_axi.ARREADY;
    assign w_r_hs  = s_axi.RVALID  & s_axi.RREADY;

    // The half that arrived first comes from the latch, the other from the bus
    assign w_addr = (r_wst == W_HAVE_AW) ? r_awaddr : s_axi.AWADDR;
    assign w_data = (r_wst == W_HAVE_W)  ? r_wdata  : s_axi.WDATA;
    assign w_strb = (r_wst == W_HAVE_W)  ? r_wstrb  : s_axi.WSTRB;

    always_comb begin
        w_wst_nxt = r_wst;
        w_commit  = 1'b0;
        case (r_wst)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wst_nxt = W_RESP;
                    w_commit  = 1'b1;
                end else if (w_aw_hs) begin
                    w_wst_nxt = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wst_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_w_hs) begin
                    w_wst_nxt = W_RESP;
                    w_commit  = 1'b1;
                end
            end
            W_HAVE_W: begin
                if (w_aw_hs) begin
                    w_wst_nxt = W_RESP;
                    w_commit  = 1'b1;
                end
            end
            W_RESP: begin
                if (w_b_hs) w_wst_nxt = W_IDLE;
            end
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rst_nxt = r_rst;
        case (r_rst)
            R_IDLE:  if (w_ar_hs) w_rst_nxt = R_DATA;
            R_DATA:  if (w_r_hs)  w_rst_nxt = R_IDLE;
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_hit  = '0;
        w_rd_hit  = '0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i] = (w_addr == ADDR_W'(i));
            w_rd_hit[i] = (s_axi.ARADDR == ADDR_W'(i));
            if (w_rd_hit[i]) w_rd_data = r_regs[i];
        end
    end

    // A write errors when it hits no writable register (out of range or read-only)
    assign w_wr_err = ~|(w_wr_hit & ~RO_MASK);
    assign w_rd_err = ~|w_rd_hit;
    assign w_sel    = w_wr_hit & ~RO_MASK & {NUM_REGS{w_commit}};

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            r_live     <= 1'b0;
            r_wst      <= W_IDLE;
            r_rst      <= R_IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_live     <= 1'b1;
            r_wst      <= w_wst_nxt;
            r_rst      <= w_rst_nxt;
            r_wr_pulse <= w_sel;
            if (w_aw_hs) r_awaddr <= s_axi.AWADDR;
            if (w_w_hs) begin
                r_wdata <= s_axi.WDATA;
                r_wstrb <= s_axi.WSTRB;
            end
            if (w_commit) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            if (w_ar_hs) begin
                r_rdata <= w_rd_err ? '0 : w_rd_data;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        axi_strb_merge #(.DATA_W(DATA_W)) u_merge (
            .i_old  (r_regs[i]),
            .i_new  (w_data),
            .i_strb (w_strb),
            .o_data (w_merged[i])
        );

        always_ff @(posedge ACLK or negedge ARESET) begin
            if (!ARESET)       r_regs[i] <= RESET_VAL;
            else if (w_sel[i]) r_regs[i] <= w_merged[i];
        end

        assign reg_out[i*DATA_W +: DATA_W] = r_regs[i];
    end

    assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Scoreboard bench for the AXI-Lite register file: stimulus pushes expected
// responses from a byte-level register model, a negedge monitor pops and compares.
module tb_axi_lite_regfile_slave;
    import axi_lite_pkg::*;

    localparam int              NR  = 8;
    localparam int              DW  = 32;
    localparam int              AW  = 32;
    localparam logic [NR-1:0]   ROM = 8'h80;
    localparam logic [DW-1:0]   RV  = 32'h0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic                ACLK;
    logic                ARESET;
    logic [NR*DW-1:0]    reg_out;
    logic [NR-1:0]       wr_pulse;

    axi_lite_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    axi_lite_regfile_slave #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(ROM), .RESET_VAL(RV)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .s_axi    (bus.slave),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int           checks = 0;
    int           errors = 0;
    int           bcount = 0;
    logic [31:0]  model [NR];
    logic [1:0]   bq [$];
    rexp_t        rq [$];
    int           pq [$];
    logic [1:0]   mon_b;
    rexp_t        mon_r;
    int           mon_p;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: bytes of a word array, error for out of range or read-only
    function automatic logic [1:0] mwrite(input int a, input logic [31:0] d, input logic [3:0] s);
        if (a >= NR) return RESP_SLVERR;
        if (ROM[a[2:0]]) return RESP_SLVERR;
        for (int b = 0; b < 4; b++)
            if (s[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        return RESP_OKAY;
    endfunction

    function automatic rexp_t mread(input int a);
        rexp_t e;
        if (a >= NR) begin
            e.data = '0;
            e.resp = RESP_SLVERR;
        end else begin
            e.data = model[a];
            e.resp = RESP_OKAY;
        end
        return e;
    endfunction

    always @(negedge ACLK) begin
        if (ARESET) begin
            if (bus.BVALID && bus.BREADY) begin
                bcount++;
                if (bq.size() == 0) fail_now("b_unexpected");
                else begin
                    mon_b = bq.pop_front();
                    chk("bresp", {62'b0, bus.BRESP}, {62'b0, mon_b});
                end
            end
            if (bus.RVALID && bus.RREADY) begin
                if (rq.size() == 0) fail_now("r_unexpected");
                else begin
                    mon_r = rq.pop_front();
                    chk("rdata", {32'b0, bus.RDATA}, {32'b0, mon_r.data});
                    chk("rresp", {62'b0, bus.RRESP}, {62'b0, mon_r.resp});
                end
            end
            if (wr_pulse != '0) begin
                if (pq.size() == 0) fail_now("wr_pulse_unexpected");
                else begin
                    mon_p = pq.pop_front();
                    chk("wr_pulse", {56'b0, wr_pulse}, 64'(1) << mon_p);
                end
            end
        end
    end

    task automatic send_aw(input int a, input int dly);
        logic ok;
        int   n;
        repeat (dly) @(posedge ACLK);
        #1;
        bus.AWVALID = 1'b1;
        bus.AWADDR  = a;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge ACLK);
            ok = bus.AWREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        bus.AWVALID = 1'b0;
        if (!ok) fail_now("aw_timeout");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        logic ok;
        int   n;
        repeat (dly) @(posedge ACLK);
        #1;
        bus.WVALID = 1'b1;
        bus.WDATA  = d;
        bus.WSTRB  = s;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge ACLK);
            ok = bus.WREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        bus.WVALID = 1'b0;
        if (!ok) fail_now("w_timeout");
    endtask

    task automatic send_ar(input int a, input int dly);
        logic ok;
        int   n;
        repeat (dly) @(posedge ACLK);
        #1;
        bus.ARVALID = 1'b1;
        bus.ARADDR  = a;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge ACLK);
            ok = bus.ARREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        bus.ARVALID = 1'b0;
        if (!ok) fail_now("ar_timeout");
    endtask

    task automatic recv_b(input int hold);
        int n = 0;
        while (!bus.BVALID && n < 64) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (!bus.BVALID) fail_now("b_timeout");
        repeat (hold) begin
            @(negedge ACLK);
            chk("bvalid_hold", {63'b0, bus.BVALID}, 64'd1);
            @(posedge ACLK);
            #1;
        end
        bus.BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic recv_r(input int hold);
        int n = 0;
        while (!bus.RVALID && n < 64) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        if (!bus.RVALID) fail_now("r_timeout");
        repeat (hold) begin
            @(negedge ACLK);
            chk("rvalid_hold", {63'b0, bus.RVALID}, 64'd1);
            @(posedge ACLK);
            #1;
        end
        bus.RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        bus.RREADY = 1'b0;
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NR; i++)
            chk(name, {32'b0, reg_out[i*DW +: DW]}, {32'b0, model[i]});
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s,
                      input int da, input int dw, input int bd);
        logic [1:0] e;
        e = mwrite(a, d, s);
        bq.push_back(e);
        if (e == RESP_OKAY) pq.push_back(a);
        fork
            send_aw(a, da);
            send_w(d, s, dw);
        join
        recv_b(bd);
        check_regs("reg_out");
    endtask

    task automatic rd(input int a, input int dar, input int rh);
        rq.push_back(mread(a));
        send_ar(a, dar);
        recv_r(rh);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_awready"}, {63'b0, bus.AWREADY}, 64'd0);
        chk({name, "_wready"},  {63'b0, bus.WREADY},  64'd0);
        chk({name, "_arready"}, {63'b0, bus.ARREADY}, 64'd0);
        chk({name, "_bvalid"},  {63'b0, bus.BVALID},  64'd0);
        chk({name, "_rvalid"},  {63'b0, bus.RVALID},  64'd0);
        chk({name, "_rdata"},   {32'b0, bus.RDATA},   64'd0);
        chk({name, "_wr_pulse"}, {56'b0, wr_pulse},   64'd0);
        for (int i = 0; i < NR; i++)
            chk({name, "_reg"}, {32'b0, reg_out[i*DW +: DW]}, {32'b0, RV});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          b0;
        logic [31:0] rd_d;
        logic [3:0]  rd_s;
        rexp_t       old3;
        logic [1:0]  e;

        for (int i = 0; i < NR; i++) model[i] = RV;
        ARESET      = 1'b0;
        bus.AWVALID = 1'b0; bus.AWADDR = '0;
        bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB = '0;
        bus.BREADY  = 1'b0;
        bus.ARVALID = 1'b0; bus.ARADDR = '0;
        bus.RREADY  = 1'b0;

        repeat (3) @(posedge ACLK);
        #1;
        check_idle_outputs("reset");
        @(negedge ACLK);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;

        // Same-cycle AW/W, low two lanes over zero
        wr(1, 32'h12345678, 4'b0011, 0, 0, 0);
        chk("req34_reg1", {32'b0, reg_out[1*DW +: DW]}, 64'h0000_5678);

        // W two cycles ahead of AW, BREADY held off for three cycles
        b0 = bcount;
        wr(3, 32'h12345678, 4'b1101, 2, 0, 3);
        chk("req35_reg3", {32'b0, reg_out[3*DW +: DW]}, 64'h1234_0078);
        chk("req35_bcount", 64'(bcount - b0), 64'd1);

        // Read-only and out-of-range accesses
        wr(7, 32'hDEADBEEF, 4'b1111, 0, 1, 0);
        wr(8, 32'hCAFEF00D, 4'b1111, 1, 0, 0);
        rd(8, 0, 1);
        rd(7, 0, 0);

        // Read and write of reg3 captured at the same edge
        old3 = mread(3);
        rq.push_back(old3);
        e = mwrite(3, 32'hFFFFFFFF, 4'b1111);
        bq.push_back(e);
        pq.push_back(3);
        fork
            send_aw(3, 0);
            send_w(32'hFFFFFFFF, 4'b1111, 0);
            send_ar(3, 0);
        join
        fork
            recv_b(0);
            recv_r(0);
        join
        rd(3, 0, 0);

        // Random mixed traffic including zero strobes and random handshake order
        for (int k = 0; k < 80; k++) begin
            rd_d = $urandom;
            rd_s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                wr(int'($urandom_range(0, 9)), rd_d, rd_s,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
            else
                rd(int'($urandom_range(0, 9)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
        end

        // Reset with a half-written transaction and an unclaimed read
        send_aw(2, 0);
        send_ar(0, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check_idle_outputs("midreset");
        for (int i = 0; i < NR; i++) model[i] = RV;
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        chk("release_awready_low", {63'b0, bus.AWREADY}, 64'd0);
        @(negedge ACLK);
        chk("release_awready", {63'b0, bus.AWREADY}, 64'd1);
        chk("release_wready",  {63'b0, bus.WREADY},  64'd1);
        chk("release_arready", {63'b0, bus.ARREADY}, 64'd1);
        @(posedge ACLK);
        #1;
        wr(0, 32'hA5A5_1234, 4'b1111, 0, 0, 0);
        rd(0, 0, 0);
        rd(2, 0, 0);

        repeat (5) @(posedge ACLK);
        chk("bq_drained", 64'(bq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        chk("pq_drained", 64'(pq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
